// File: rtl/qoi_mem_arbiter.sv
// qoi_mem_arbiter: ownership-token arbiter for the shared pixel buffer between the CPU and the QOI engine.
// Optional QOI_ARB_SHARE_EN lets idle engine cycles service CPU reads while the engine owns the buffer.
module qoi_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] HANDOFF_ADDR = 10'h3FF,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_rvalid,
  input  logic              acc_release,
  input  logic              abort,
  input  logic              cnt_clr,
  output logic              owner_o,
  output logic              flag_o,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {CPU_OWN, TO_ACC, ACC_OWN, TO_CPU} state_t;
  state_t r_state, w_next;
  logic r_owner, r_flag, w_flag_next, r_cpu_rd, r_acc_rd;
  logic [DATA_W-1:0] r_cpu_hold, r_acc_hold;
  logic [CNT_W-1:0] r_cnt;
  logic w_share, w_cpu_ok, w_acc_ok, w_drop;
`ifdef QOI_ARB_SHARE_EN
  assign w_share = (r_state == ACC_OWN) && !acc_req && !cpu_we;
`else
  assign w_share = 1'b0;
`endif
  assign w_cpu_ok = cpu_cs && !abort && ((r_state == CPU_OWN) || w_share);
  assign w_acc_ok = (r_state == ACC_OWN) && acc_req && !abort;
  assign w_drop   = cpu_cs && !w_cpu_ok;
  assign acc_gnt   = w_acc_ok;
  assign ram_cs    = w_cpu_ok || w_acc_ok;
  assign ram_we    = w_acc_ok ? acc_we : (w_cpu_ok && cpu_we);
  assign ram_addr  = w_acc_ok ? acc_addr : cpu_addr;
  assign ram_wdata = w_acc_ok ? acc_wdata : cpu_wdata;
  // Read data is presented straight from the RAM output in the rvalid cycle, then held.
  assign cpu_rvalid = r_cpu_rd;
  assign cpu_rdata  = r_cpu_rd ? ram_rdata : r_cpu_hold;
  assign acc_rvalid = r_acc_rd && !abort;
  assign acc_rdata  = r_acc_rd ? ram_rdata : r_acc_hold;
  assign owner_o  = r_owner;
  assign flag_o   = r_flag;
  assign drop_cnt = r_cnt;
  always_comb begin
    w_next = r_state;
    w_flag_next = r_flag;
    if (abort) begin
      w_next = CPU_OWN;
      w_flag_next = 1'b1;
    end else begin
      case (r_state)
        CPU_OWN: if (w_cpu_ok && cpu_we && cpu_addr == HANDOFF_ADDR) begin
          w_next = TO_ACC;
          w_flag_next = 1'b0;
        end
        TO_ACC:  w_next = ACC_OWN;
        ACC_OWN: if (acc_release) w_next = TO_CPU;
        default: begin
          w_next = CPU_OWN;
          w_flag_next = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CPU_OWN;
      r_owner    <= 1'b0;
      r_flag     <= 1'b0;
      r_cpu_rd   <= 1'b0;
      r_acc_rd   <= 1'b0;
      r_cpu_hold <= '0;
      r_acc_hold <= '0;
      r_cnt      <= '0;
    end else begin
      r_state  <= w_next;
      r_owner  <= (w_next == TO_ACC) || (w_next == ACC_OWN);
      r_flag   <= w_flag_next;
      r_cpu_rd <= w_cpu_ok && !cpu_we;
      r_acc_rd <= w_acc_ok && !acc_we;
      if (r_cpu_rd) r_cpu_hold <= ram_rdata;
      if (r_acc_rd) r_acc_hold <= ram_rdata;
      r_cnt <= cnt_clr ? '0 : (w_drop && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule
